// File: rtl/cache_way_mem.sv
// rtl/cache_way_mem.sv - per-way {valid, tag, data} storage with valid-bit sweep; optional parity via CACHE_WAY_MEM_PARITY_EN
module cache_way_mem #(
    parameter int NUM_WAYS     = 8,
    parameter int NUM_SETS     = 256,
    parameter int ADDR_WIDTH   = 64,
    parameter int OFFSET_WIDTH = 4,
    parameter int TAG_WIDTH    = 44,
    parameter int LINE_WIDTH   = 128
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_i,
    output logic                             ready_o,
    input  logic [NUM_WAYS-1:0]              req_i,
    input  logic [ADDR_WIDTH-1:0]            addr_i,
    input  logic                             we_i,
    input  logic                             wdata_valid_i,
    input  logic [TAG_WIDTH-1:0]             wdata_tag_i,
    input  logic [LINE_WIDTH-1:0]            wdata_data_i,
    input  logic                             be_valid_i,
    input  logic                             be_tag_i,
    input  logic [LINE_WIDTH/8-1:0]          be_data_i,
    output logic [NUM_WAYS-1:0]              rdata_valid_o,
    output logic [NUM_WAYS*TAG_WIDTH-1:0]    rdata_tag_o,
    output logic [NUM_WAYS*LINE_WIDTH-1:0]   rdata_data_o,
    output logic [NUM_WAYS-1:0]              err_o
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int BYTES = LINE_WIDTH / 8;
    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_FLUSH} state_t;

    state_t           r_state, w_state_nx;
    logic [IDX_W-1:0] r_cnt, w_cnt_nx;
    logic             w_sweep, w_acc, w_rd;
    logic [IDX_W-1:0] w_idx;
    logic             w_unused;

    logic                  r_valid [NUM_WAYS][NUM_SETS];
    logic [TAG_WIDTH-1:0]  r_tag   [NUM_WAYS][NUM_SETS];
    logic [LINE_WIDTH-1:0] r_data  [NUM_WAYS][NUM_SETS];

    logic [NUM_WAYS-1:0]            r_rv;
    logic [NUM_WAYS*TAG_WIDTH-1:0]  r_rt;
    logic [NUM_WAYS*LINE_WIDTH-1:0] r_rd;

    assign w_idx    = addr_i[OFFSET_WIDTH +: IDX_W];
    assign w_unused = ^{addr_i[ADDR_WIDTH-1:OFFSET_WIDTH+IDX_W], addr_i[OFFSET_WIDTH-1:0]};
    assign w_acc    = (r_state == S_IDLE);
    assign w_sweep  = ~w_acc;
    assign w_rd     = w_acc & ~we_i;
    assign ready_o  = w_acc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // INIT and FLUSH share the same sweep; flush_i is only looked at in IDLE
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            S_INIT, S_FLUSH: begin
                w_cnt_nx = r_cnt + IDX_W'(1);
                if (r_cnt == LAST_SET) w_state_nx = S_IDLE;
            end
            S_IDLE: begin
                if (flush_i) w_state_nx = S_FLUSH;
            end
            default: w_state_nx = S_INIT;
        endcase
    end

`ifdef CACHE_WAY_MEM_PARITY_EN
    logic                  r_par [NUM_WAYS][NUM_SETS];
    logic [NUM_WAYS-1:0]   r_err;
    logic                  w_mv;
    logic [TAG_WIDTH-1:0]  w_mt;
    logic [LINE_WIDTH-1:0] w_md;
    logic [NUM_WAYS-1:0]   w_wpar;

    // parity of the entry as it will look after the byte-enabled merge
    always_comb begin
        w_mv   = 1'b0;
        w_mt   = '0;
        w_md   = '0;
        w_wpar = '0;
        for (int j = 0; j < NUM_WAYS; j++) begin
            w_mv = be_valid_i ? wdata_valid_i : r_valid[j][w_idx];
            w_mt = be_tag_i ? wdata_tag_i : r_tag[j][w_idx];
            w_md = r_data[j][w_idx];
            for (int b = 0; b < BYTES; b++)
                if (be_data_i[b]) w_md[8*b +: 8] = wdata_data_i[8*b +: 8];
            w_wpar[j] = ^{w_mv, w_mt, w_md};
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        for (int j = 0; j < NUM_WAYS; j++) begin
            if (w_sweep) begin
                r_valid[j][r_cnt] <= 1'b0;
`ifdef CACHE_WAY_MEM_PARITY_EN
                r_par[j][r_cnt] <= ^{r_tag[j][r_cnt], r_data[j][r_cnt]};
`endif
            end else if (we_i && req_i[j]) begin
                if (be_valid_i) r_valid[j][w_idx] <= wdata_valid_i;
                if (be_tag_i)   r_tag[j][w_idx]   <= wdata_tag_i;
                for (int b = 0; b < BYTES; b++)
                    if (be_data_i[b]) r_data[j][w_idx][8*b +: 8] <= wdata_data_i[8*b +: 8];
`ifdef CACHE_WAY_MEM_PARITY_EN
                r_par[j][w_idx] <= w_wpar[j];
`endif
            end
        end
    end

    // unrequested ways and write cycles leave the read registers untouched
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rv <= '0;
            r_rt <= '0;
            r_rd <= '0;
        end else begin
            for (int j = 0; j < NUM_WAYS; j++) begin
                if (w_rd && req_i[j]) begin
                    r_rv[j]                          <= r_valid[j][w_idx];
                    r_rt[j*TAG_WIDTH +: TAG_WIDTH]   <= r_tag[j][w_idx];
                    r_rd[j*LINE_WIDTH +: LINE_WIDTH] <= r_data[j][w_idx];
                end
            end
        end
    end

`ifdef CACHE_WAY_MEM_PARITY_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= '0;
        end else begin
            for (int j = 0; j < NUM_WAYS; j++)
                r_err[j] <= w_rd && req_i[j] &&
                            (r_par[j][w_idx] != ^{r_valid[j][w_idx], r_tag[j][w_idx], r_data[j][w_idx]});
        end
    end
    assign err_o = r_err;
`else
    assign err_o = '0;
`endif

    assign rdata_valid_o = r_rv;
    assign rdata_tag_o   = r_rt;
    assign rdata_data_o  = r_rd;

endmodule

// File: tb/tb_cache_way_mem.sv
// tb/tb_cache_way_mem.sv - scoreboard bench for cache_way_mem
module tb_cache_way_mem;
    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           flush_i = 1'b0;
    logic           ready_o;
    logic [7:0]     req_i = '0;
    logic [63:0]    addr_i = '0;
    logic           we_i = 1'b0;
    logic           wdata_valid_i = 1'b0;
    logic [43:0]    wdata_tag_i = '0;
    logic [127:0]   wdata_data_i = '0;
    logic           be_valid_i = 1'b0;
    logic           be_tag_i = 1'b0;
    logic [15:0]    be_data_i = '0;
    logic [7:0]     rdata_valid_o;
    logic [351:0]   rdata_tag_o;
    logic [1023:0]  rdata_data_o;
    logic [7:0]     err_o;

    cache_way_mem dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .ready_o(ready_o),
        .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
        .wdata_valid_i(wdata_valid_i), .wdata_tag_i(wdata_tag_i), .wdata_data_i(wdata_data_i),
        .be_valid_i(be_valid_i), .be_tag_i(be_tag_i), .be_data_i(be_data_i),
        .rdata_valid_o(rdata_valid_o), .rdata_tag_o(rdata_tag_o), .rdata_data_o(rdata_data_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic         rdy;
        logic [7:0]   v;
        logic [7:0]   e;
        logic [7:0]   tk;
        logic [7:0]   dk;
        logic [351:0] t;
        logic [1023:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   left    = 0;

    logic         m_valid [8][256];
    logic [43:0]  m_tag   [8][256];
    logic [127:0] m_data  [8][256];
    bit           m_tk    [8][256];
    bit           m_dk    [8][256];
    logic [7:0]   exp_v;
    logic [43:0]  exp_t_r [8];
    logic [127:0] exp_d_r [8];
    logic [7:0]   exp_tk, exp_dk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 8; j++) begin
            for (int s = 0; s < 256; s++) m_valid[j][s] = 1'b0;
            exp_t_r[j] = '0;
            exp_d_r[j] = '0;
        end
        exp_v  = '0;
        exp_tk = '1;
        exp_dk = '1;
        left   = 256;
    endtask

    task automatic cyc(input logic [7:0] req, input logic [63:0] addr, input logic we, input logic fl,
                       input logic wv, input logic [43:0] wt, input logic [127:0] wd,
                       input logic bv, input logic bt, input logic [15:0] bd, input logic [7:0] perr);
        exp_t x;
        int   idx;
        logic acc;
        req_i = req; addr_i = addr; we_i = we; flush_i = fl;
        wdata_valid_i = wv; wdata_tag_i = wt; wdata_data_i = wd;
        be_valid_i = bv; be_tag_i = bt; be_data_i = bd;
        idx = int'(addr[11:4]);
        acc = (left == 0);
        if (acc) begin
            for (int j = 0; j < 8; j++) begin
                if (req[j] && !we) begin
                    exp_v[j]   = m_valid[j][idx];
                    exp_t_r[j] = m_tag[j][idx];
                    exp_d_r[j] = m_data[j][idx];
                    exp_tk[j]  = m_tk[j][idx];
                    exp_dk[j]  = m_dk[j][idx];
                end else if (req[j]) begin
                    if (bv) m_valid[j][idx] = wv;
                    if (bt) begin m_tag[j][idx] = wt; m_tk[j][idx] = 1'b1; end
                    for (int b = 0; b < 16; b++)
                        if (bd[b]) m_data[j][idx][8*b +: 8] = wd[8*b +: 8];
                    if (&bd) m_dk[j][idx] = 1'b1;
                end
            end
        end
        x.e = (acc && !we) ? (perr & req) : 8'h00;
        if (acc && fl) begin
            left = 256;
            for (int j = 0; j < 8; j++)
                for (int s = 0; s < 256; s++) m_valid[j][s] = 1'b0;
        end else if (left > 0) begin
            left--;
        end
        x.rdy = (left == 0);
        x.v = exp_v; x.tk = exp_tk; x.dk = exp_dk;
        for (int j = 0; j < 8; j++) begin
            x.t[j*44 +: 44]   = exp_t_r[j];
            x.d[j*128 +: 128] = exp_d_r[j];
        end
        sb.push_back(x);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        x = sb.pop_front();
        check_eq("ready", {127'd0, ready_o}, {127'd0, x.rdy});
        check_eq("valid", {120'd0, rdata_valid_o}, {120'd0, x.v});
        check_eq("err", {120'd0, err_o}, {120'd0, x.e});
        for (int j = 0; j < 8; j++) begin
            if (x.tk[j]) check_eq($sformatf("tag%0d", j), {84'd0, rdata_tag_o[j*44 +: 44]}, {84'd0, x.t[j*44 +: 44]});
            if (x.dk[j]) check_eq($sformatf("data%0d", j), rdata_data_o[j*128 +: 128], x.d[j*128 +: 128]);
        end
    endtask

    task automatic idle();
        cyc('0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic rd(input logic [7:0] req, input logic [63:0] addr);
        cyc(req, addr, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wr(input logic [7:0] req, input logic [63:0] addr, input logic wv, input logic [43:0] wt,
                      input logic [127:0] wd, input logic bv, input logic bt, input logic [15:0] bd);
        cyc(req, addr, 1'b1, 1'b0, wv, wt, wd, bv, bt, bd, '0);
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        repeat (n) @(posedge clk_i);
        #1;
        check_eq("rst_ready", {127'd0, ready_o}, 128'd0);
        check_eq("rst_valid", {120'd0, rdata_valid_o}, 128'd0);
        check_eq("rst_tag", {127'd0, |rdata_tag_o}, 128'd0);
        check_eq("rst_data", {127'd0, |rdata_data_o}, 128'd0);
        check_eq("rst_err", {120'd0, err_o}, 128'd0);
        model_reset();
        rst_i = 1'b0;
    endtask

    task automatic sweep_len(input string tag, input int flush_at);
        int n;
        n = 0;
        while (!ready_o && n < 1000) begin
            n++;
            if (n == flush_at) cyc(8'hFF, 64'h50, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
            else idle();
        end
        check_eq(tag, 128'(n), 128'd256);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pat;
        model_reset();
        do_reset(260);
        sweep_len("init_len", 0);
        rd(8'hFF, 64'h0);
        rd(8'hFF, 64'hFF0);

        wr(8'h08, 64'h50, 1'b1, 44'h1234, {16{8'hAA}}, 1'b1, 1'b1, 16'hFFFF);
        rd(8'hFF, 64'h50);
        rd(8'h08, 64'hABCD_0000_0000_005F);

        wr(8'h08, 64'h50, 1'b0, 44'hFFF, {16{8'h55}}, 1'b0, 1'b0, 16'h0001);
        rd(8'h08, 64'h50);

        rd(8'h08, 64'h50);
        idle();
        wr(8'h08, 64'h50, 1'b1, 44'h777, {4{32'hDEAD_BEEF}}, 1'b1, 1'b1, 16'hFFFF);
        idle();
        rd(8'h08, 64'h50);

        wr(8'h30, 64'h20, 1'b1, 44'hABC, {8{16'h1357}}, 1'b1, 1'b1, 16'hFFFF);
        rd(8'hFF, 64'h20);

        cyc(8'hFF, 64'h50, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        sweep_len("flush_len", 100);
        rd(8'h08, 64'h50);
        rd(8'hFF, 64'h20);

        pat = {$urandom, $urandom, $urandom, $urandom};
        wr(8'h04, 64'h70, 1'b1, 44'h5A5, pat, 1'b1, 1'b1, 16'hFFFF);
`ifdef CACHE_WAY_MEM_PARITY_EN
        dut.r_data[2][7][0] = ~dut.r_data[2][7][0];
        m_data[2][7][0] = ~m_data[2][7][0];
        cyc(8'h04, 64'h70, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 8'h04);
`else
        cyc(8'h04, 64'h70, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 8'h00);
`endif
        idle();

        cyc(8'h00, 64'h0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        repeat (10) idle();
        do_reset(3);
        sweep_len("abort_len", 0);
        rd(8'hFF, 64'h50);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/cache_way_mem.md
Name: cache_way_mem

Overview:
Set-associative cache storage array: the memory-side responder of the way-parallel cache access interface.
- Accepts one request per cycle with a per-way request vector, address, write enable, byte enables and write data.
- Returns per-way {valid, tag, data} one cycle later, for downstream tag comparison.
- Contains the valid-bit initialisation/flush sweep.
- Replaces the behavioural SRAM instances under the data cache.

Parameters:
NUM_WAYS, 8, number of ways (one storage bank per way)
NUM_SETS, 256, sets per way (power of two)
ADDR_WIDTH, 64, request address width
OFFSET_WIDTH, 4, byte-offset bits below the set index
TAG_WIDTH, 44, tag field width
LINE_WIDTH, 128, data bits per line (multiple of 8)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
flush_i  in  1  single-cycle pulse: invalidate all lines
ready_o  out  1  array accepts requests
req_i  in  NUM_WAYS  per-way request
addr_i  in  ADDR_WIDTH  byte address; index = addr_i[OFFSET_WIDTH +: log2(NUM_SETS)]
we_i  in  1  write (1) / read (0), applies to all requested ways
wdata_valid_i  in  1  valid bit to write
wdata_tag_i  in  TAG_WIDTH  tag to write
wdata_data_i  in  LINE_WIDTH  line data to write
be_valid_i  in  1  valid-bit write enable
be_tag_i  in  1  tag write enable
be_data_i  in  LINE_WIDTH/8  data byte enables
rdata_valid_o  out  NUM_WAYS  per-way valid bit
rdata_tag_o  out  NUM_WAYS*TAG_WIDTH  per-way tag
rdata_data_o  out  NUM_WAYS*LINE_WIDTH  per-way data
err_o  out  NUM_WAYS  per-way parity error (see optional feature)

Behaviour:
Reset (rst_i high, asynchronous):
- FSM goes to INIT; sweep counter = 0; ready_o = 0.
- All rdata_* outputs = 0; err_o = 0.
- Tag and data contents are undefined; only valid bits are cleared by the sweep.

FSM states:
- INIT:
  - Each cycle, clears the valid bit of set = counter in every way, then counter++.
  - At counter = NUM_SETS-1, the clear is performed and the FSM goes to IDLE.
  - Duration is exactly NUM_SETS cycles; counter wraps to 0.
  - ready_o = 0.
- IDLE:
  - ready_o = 1; requests are serviced.
  - flush_i = 1 -> FLUSH next cycle; a request presented in the same cycle is still serviced.
- FLUSH:
  - Identical to INIT; returns to IDLE after NUM_SETS cycles.
  - flush_i during FLUSH is ignored; the sweep does not restart.

Request handling (IDLE only):
- While ready_o = 0, req_i is ignored: no write occurs and rdata_* holds.
- Read (we_i = 0): for each way j with req_i[j] = 1, the entry at index is registered onto way j's rdata_* at the next edge (latency 1). Ways with req_i[j] = 0 hold their previous rdata_*.
- Write (we_i = 1): for each requested way:
  - valid updated iff be_valid_i;
  - tag updated iff be_tag_i;
  - data byte b updated iff be_data_i[b].
  - rdata_* for written ways holds (no read-through).
  - A read of the same set on the next cycle returns the new contents.
- Tag/offset bits of addr_i outside the index field are ignored.
- Multiple ways may be requested at once (fill/evict reads all ways; a write normally targets one way). Writing several ways writes identical values.
- Reset asserted mid-sweep or mid-access aborts it; the sweep restarts from set 0.

Optional Feature:
Macro CACHE_WAY_MEM_PARITY_EN.
- Defined:
  - Each entry stores one even-parity bit over {valid, tag, data}, recomputed on every write or sweep clear from the resulting merged entry.
  - On a read, err_o[j] = 1 for one cycle, aligned with rdata_*, when stored parity mismatches.
  - err_o = 0 on write cycles and during INIT/FLUSH.
- Not defined: no parity storage; err_o tied to 0.

Test Plan:
1. Reset, hold 260 cycles -> ready_o = 0 for exactly 256 cycles after deassert, then 1; read all ways of set 0 and set 255 -> rdata_valid_o = 8'h00.
2. Write way 3, set 5 (addr 0x50), valid = 1, tag = 0x1234, data = all 0xAA, all enables set; next cycle read req_i = 8'hFF, addr 0x50 -> one cycle later way 3 shows valid = 1, tag 0x1234, data 0xAA..AA; other ways valid = 0.
3. Partial write to way 3, set 5: be_data_i = 16'h0001, data byte 0 = 0x55, be_tag_i = 0 -> read returns byte 0 = 0x55, bytes 1-15 = 0xAA, tag unchanged 0x1234.
4. Read way 3, then a request with req_i = 0 -> rdata for way 3 holds; issue a write to way 3 -> rdata holds the old value during and after the write cycle.
5. flush_i in IDLE together with a read of set 5 -> the read completes; ready_o = 0 next cycle for 256 cycles; flush_i again mid-sweep -> no extension; afterwards set 5 way 3 valid = 0.
6. With CACHE_WAY_MEM_PARITY_EN, force-corrupt one stored data bit of way 2, set 7 and read it -> err_o = 8'h04 for one cycle; without the macro -> err_o = 0.
